// File: rtl/mc_pkg.sv
// Shared types and helpers for the Longstaff-Schwartz pricing core.
package mc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMaturity,
        StFit,
        StUpdate,
        StAverage,
        StDone
    } mc_state_e;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int unsigned f_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Call/put exercise value, never negative; operands are zero-extended W-bit values.
    function automatic logic [31:0] f_payoff(input logic [31:0] s, input logic [31:0] k,
                                             input logic put);
        if (put) begin
            return (k > s) ? (k - s) : 32'd0;
        end
        return (s > k) ? (s - k) : 32'd0;
    endfunction

    // One-day discount: cf * disc in Q0.w, truncated; full-width product avoids overflow.
    function automatic logic [31:0] f_discount(input logic [31:0] cf, input logic [31:0] disc,
                                               input int unsigned w);
        logic [63:0] prod;
        prod = {32'd0, cf} * {32'd0, disc};
        return 32'(prod >> w);
    endfunction

endpackage

// File: rtl/mc_cf_mem.sv
// Per-path storage: one combinational read and one write per cycle at the same address.
module mc_cf_mem #(
    parameter int unsigned N_PATH = 128,
    parameter int unsigned W      = 12,
    parameter int unsigned AW     = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_addr,
    input  logic          i_we,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [N_PATH];

    // Reset clears every entry so an aborted run leaves no stale cash flows.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N_PATH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mc_lsm_engine.sv
// Longstaff-Schwartz Monte-Carlo core: maturity payoffs, backward induction with an
// external regression unit, then path averaging.
module mc_lsm_engine
    import mc_pkg::*;
#(
    parameter int unsigned N_PATH = 128,
    parameter int unsigned N_DAY  = 8,
    parameter int unsigned W      = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] strike,
    input  logic         is_put,
    input  logic [W-1:0] disc,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_price,
    output logic         reg_valid,
    input  logic         reg_ready,
    output logic [W-1:0] reg_ex,
    output logic [W-1:0] reg_cf,
    input  logic         est_valid,
    output logic         est_ready,
    input  logic [W-1:0] est_value,
    output logic         busy,
    output logic         price_valid,
    output logic [W-1:0] price
);

    localparam int unsigned PATH_W = $clog2(N_PATH);
    localparam int unsigned DAY_W  = f_idx_w(N_DAY);
    localparam int unsigned SUM_W  = W + PATH_W;
    localparam logic [PATH_W-1:0] LAST_PATH = PATH_W'(N_PATH - 1);

    mc_state_e         r_state;
    logic [PATH_W-1:0] r_path;
    logic [DAY_W-1:0]  r_day;
    logic [W-1:0]      r_strike;
    logic              r_is_put;
    logic [W-1:0]      r_disc;
    logic [SUM_W-1:0]  r_sum;
    logic [W-1:0]      r_price;

    logic [W-1:0]     w_payoff;
    logic [W-1:0]     w_cf_rd;
    logic [W-1:0]     w_cf_d;
    logic [W-1:0]     w_ex_rd;
    logic             w_cf_we;
    logic [W-1:0]     w_cf_wd;
    logic             w_ex_we;
    logic [W-1:0]     w_ex_wd;
    logic [SUM_W-1:0] w_sum_next;
    logic             w_last;

    assign w_payoff   = W'(f_payoff(32'(in_price), 32'(r_strike), r_is_put));
    assign w_cf_d     = W'(f_discount(32'(w_cf_rd), 32'(r_disc), W));
    assign w_sum_next = r_sum + SUM_W'(w_cf_rd);
    assign w_last     = (r_path == LAST_PATH);

    assign reg_ex      = w_payoff;
    assign reg_cf      = w_cf_d;
    assign busy        = (r_state != StIdle);
    assign price_valid = (r_state == StDone);
    assign price       = r_price;

    mc_cf_mem #(.N_PATH(N_PATH), .W(W), .AW(PATH_W)) u_cf_mem (
        .clk     (clk),
        .rst     (rst),
        .i_addr  (r_path),
        .i_we    (w_cf_we),
        .i_wdata (w_cf_wd),
        .o_rdata (w_cf_rd)
    );

    mc_cf_mem #(.N_PATH(N_PATH), .W(W), .AW(PATH_W)) u_ex_mem (
        .clk     (clk),
        .rst     (rst),
        .i_addr  (r_path),
        .i_we    (w_ex_we),
        .i_wdata (w_ex_wd),
        .o_rdata (w_ex_rd)
    );

    // Handshake strobes and memory writes for the current state; FIT passes through to regression.
    always_comb begin
        in_ready  = 1'b0;
        reg_valid = 1'b0;
        est_ready = 1'b0;
        w_cf_we   = 1'b0;
        w_cf_wd   = '0;
        w_ex_we   = 1'b0;
        w_ex_wd   = '0;
        unique case (r_state)
            StMaturity: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_cf_we = 1'b1;
                    w_cf_wd = w_payoff;
                end
            end
            StFit: begin
                in_ready  = reg_ready;
                reg_valid = in_valid;
                if (in_valid && reg_ready) begin
                    w_ex_we = 1'b1;
                    w_ex_wd = w_payoff;
                    w_cf_we = 1'b1;
                    w_cf_wd = w_cf_d;
                end
            end
            StUpdate: begin
                est_ready = 1'b1;
                // Strict compare: a tie keeps the continuation cash flow.
                if (est_valid && (w_ex_rd != '0) && (w_ex_rd > est_value)) begin
                    w_cf_we = 1'b1;
                    w_cf_wd = w_ex_rd;
                end
            end
            default: ;
        endcase
    end

    // Run sequencing: path/day counters, config latch, accumulation and price register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_path   <= '0;
            r_day    <= '0;
            r_strike <= '0;
            r_is_put <= 1'b0;
            r_disc   <= '0;
            r_sum    <= '0;
            r_price  <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_strike <= strike;
                        r_is_put <= is_put;
                        r_disc   <= disc;
                        r_day    <= DAY_W'(N_DAY - 1);
                        r_path   <= '0;
                        r_state  <= StMaturity;
                    end
                end
                StMaturity: begin
                    if (in_valid) begin
                        r_path <= w_last ? '0 : r_path + 1'b1;
                        if (w_last) begin
                            if (N_DAY == 1) begin
                                r_sum   <= '0;
                                r_state <= StAverage;
                            end else begin
                                r_day   <= r_day - DAY_W'(1);
                                r_state <= StFit;
                            end
                        end
                    end
                end
                StFit: begin
                    if (in_valid && reg_ready) begin
                        r_path <= w_last ? '0 : r_path + 1'b1;
                        if (w_last) begin
                            r_state <= StUpdate;
                        end
                    end
                end
                StUpdate: begin
                    if (est_valid) begin
                        r_path <= w_last ? '0 : r_path + 1'b1;
                        if (w_last) begin
                            if (r_day == '0) begin
                                r_sum   <= '0;
                                r_state <= StAverage;
                            end else begin
                                r_day   <= r_day - DAY_W'(1);
                                r_state <= StFit;
                            end
                        end
                    end
                end
                StAverage: begin
                    r_sum  <= w_sum_next;
                    r_path <= w_last ? '0 : r_path + 1'b1;
                    if (w_last) begin
                        r_price <= w_sum_next[SUM_W-1:PATH_W];
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_lsm_engine.sv
// Directed bench: three engine instances (4x1, 4x2, 128x8) share stimulus; only one runs at a time.
module tb_mc_lsm_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a [3];
    logic [11:0] strike, disc, in_price, est_value;
    logic        is_put, in_valid, reg_ready, est_valid;

    logic        in_ready_a [3];
    logic        reg_valid_a [3];
    logic        est_ready_a [3];
    logic        busy_a [3];
    logic        price_valid_a [3];
    logic [11:0] reg_ex_a [3];
    logic [11:0] reg_cf_a [3];
    logic [11:0] price_a [3];

    int sel = 0;
    int n_checks = 0;
    int n_errors = 0;
    int pv_cnt [3] = '{0, 0, 0};

    logic        in_ready_s, reg_valid_s, est_ready_s, price_valid_s;
    logic [11:0] reg_ex_s, reg_cf_s, price_s;

    logic [11:0] prices1 [4] = '{12'd110, 12'd90, 12'd150, 12'd100};
    logic [11:0] day0_px [4] = '{12'd110, 12'd90, 12'd130, 12'd100};
    logic [11:0] day0_ex [4] = '{12'd10, 12'd0, 12'd30, 12'd0};
    logic [11:0] est_low [4] = '{12'd5, 12'd5, 12'd5, 12'd5};
    logic [11:0] est_tie [4] = '{12'd10, 12'd10, 12'd30, 12'd10};

    always #5 clk = ~clk;

    assign in_ready_s    = in_ready_a[sel];
    assign reg_valid_s   = reg_valid_a[sel];
    assign est_ready_s   = est_ready_a[sel];
    assign price_valid_s = price_valid_a[sel];
    assign reg_ex_s      = reg_ex_a[sel];
    assign reg_cf_s      = reg_cf_a[sel];
    assign price_s       = price_a[sel];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (price_valid_a[i]) pv_cnt[i] <= pv_cnt[i] + 1;
        end
    end

    mc_lsm_engine #(.N_PATH(4), .N_DAY(1), .W(12)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_a[0]), .strike(strike), .is_put(is_put),
        .disc(disc), .in_valid(in_valid), .in_ready(in_ready_a[0]), .in_price(in_price),
        .reg_valid(reg_valid_a[0]), .reg_ready(reg_ready), .reg_ex(reg_ex_a[0]),
        .reg_cf(reg_cf_a[0]), .est_valid(est_valid), .est_ready(est_ready_a[0]),
        .est_value(est_value), .busy(busy_a[0]), .price_valid(price_valid_a[0]),
        .price(price_a[0])
    );

    mc_lsm_engine #(.N_PATH(4), .N_DAY(2), .W(12)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_a[1]), .strike(strike), .is_put(is_put),
        .disc(disc), .in_valid(in_valid), .in_ready(in_ready_a[1]), .in_price(in_price),
        .reg_valid(reg_valid_a[1]), .reg_ready(reg_ready), .reg_ex(reg_ex_a[1]),
        .reg_cf(reg_cf_a[1]), .est_valid(est_valid), .est_ready(est_ready_a[1]),
        .est_value(est_value), .busy(busy_a[1]), .price_valid(price_valid_a[1]),
        .price(price_a[1])
    );

    mc_lsm_engine #(.N_PATH(128), .N_DAY(8), .W(12)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_a[2]), .strike(strike), .is_put(is_put),
        .disc(disc), .in_valid(in_valid), .in_ready(in_ready_a[2]), .in_price(in_price),
        .reg_valid(reg_valid_a[2]), .reg_ready(reg_ready), .reg_ex(reg_ex_a[2]),
        .reg_cf(reg_cf_a[2]), .est_valid(est_valid), .est_ready(est_ready_a[2]),
        .est_value(est_value), .busy(busy_a[2]), .price_valid(price_valid_a[2]),
        .price(price_a[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid  = 1'b0;
        est_valid = 1'b0;
        reg_ready = 1'b1;
    endtask

    task automatic start_run(input int s, input logic [11:0] k, input logic put,
                             input logic [11:0] d);
        @(negedge clk);
        sel        = s;
        strike     = k;
        is_put     = put;
        disc       = d;
        start_a[s] = 1'b1;
        @(negedge clk);
        start_a[s] = 1'b0;
    endtask

    // Offers one price until accepted; in FIT also checks the regression beat.
    task automatic send_price(input logic [11:0] p, input bit gaps, input bit fit,
                              input logic [11:0] ex_exp, input logic [11:0] cf_exp);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            in_price  = p;
            in_valid  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            reg_ready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (fit && !reg_ready) check("fit_stall_in_ready", 32'(in_ready_s), 32'd0);
            acc = in_valid && in_ready_s;
            if (acc && fit) begin
                check("reg_valid", 32'(reg_valid_s), 32'd1);
                check("reg_ex", 32'(reg_ex_s), 32'(ex_exp));
                check("reg_cf", 32'(reg_cf_s), 32'(cf_exp));
            end
            @(posedge clk);
            n++;
        end
        if (!acc) check("price_beat_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_est(input logic [11:0] v, input bit gaps);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            in_valid  = 1'b0;
            est_value = v;
            est_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            acc = est_valid && est_ready_s;
            @(posedge clk);
            n++;
        end
        if (!acc) check("est_beat_timeout", 32'(acc), 32'd1);
    endtask

    // Call right after the final accepted beat; lat counts cycles to the price pulse.
    task automatic wait_price(input string tag, input logic [11:0] exp, input int lat);
        bit got = 1'b0;
        int n = 0;
        while (!got && n < 1000) begin
            @(negedge clk);
            n++;
            got = price_valid_s;
        end
        check({tag, "_valid"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, "_price"}, 32'(price_s), 32'(exp));
            if (lat >= 0) check({tag, "_latency"}, n, lat);
            @(negedge clk);
            check({tag, "_pulse_width"}, 32'(price_valid_s), 32'd0);
            check({tag, "_price_hold"}, 32'(price_s), 32'(exp));
        end
    endtask

    task automatic run_one_day(input logic put, input logic [11:0] exp);
        int pv0;
        pv0 = pv_cnt[0];
        start_run(0, 12'd100, put, 12'd0);
        for (int i = 0; i < 4; i++) send_price(prices1[i], 1'b0, 1'b0, 12'd0, 12'd0);
        wait_price(put ? "put1" : "call1", exp, 5);
        idle();
        check("single_pulse", pv_cnt[0] - pv0, 1);
    endtask

    task automatic run_two_day(input string tag, input bit tie, input bit gaps,
                               input logic [11:0] exp);
        start_run(1, 12'd100, 1'b0, 12'd2048);
        for (int i = 0; i < 4; i++) send_price(12'd120, gaps, 1'b0, 12'd0, 12'd0);
        for (int i = 0; i < 4; i++) send_price(day0_px[i], gaps, 1'b1, day0_ex[i], 12'd10);
        for (int i = 0; i < 4; i++) send_est(tie ? est_tie[i] : est_low[i], gaps);
        wait_price(tag, exp, gaps ? -1 : 5);
        idle();
    endtask

    initial begin
        int pv1;
        for (int i = 0; i < 3; i++) start_a[i] = 1'b0;
        strike    = '0;
        disc      = '0;
        in_price  = '0;
        est_value = '0;
        is_put    = 1'b0;
        in_valid  = 1'b0;
        reg_ready = 1'b1;
        est_valid = 1'b0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_busy", 32'(busy_a[0]), 32'd0);
        check("rst_in_ready", 32'(in_ready_a[0]), 32'd0);
        check("rst_reg_valid", 32'(reg_valid_a[1]), 32'd0);
        check("rst_est_ready", 32'(est_ready_a[1]), 32'd0);
        check("rst_price_valid", 32'(price_valid_a[0]), 32'd0);
        check("rst_price", 32'(price_a[0]), 32'd0);

        run_one_day(1'b0, 12'd15);
        run_one_day(1'b1, 12'd2);

        run_two_day("two_day_exercise", 1'b0, 1'b0, 12'd15);
        run_two_day("two_day_tie", 1'b1, 1'b0, 12'd10);
        run_two_day("two_day_gaps", 1'b0, 1'b1, 12'd15);

        // Abort a run in UPDATE; no price may follow.
        pv1 = pv_cnt[1];
        start_run(1, 12'd100, 1'b0, 12'd2048);
        for (int i = 0; i < 4; i++) send_price(12'd120, 1'b0, 1'b0, 12'd0, 12'd0);
        for (int i = 0; i < 4; i++) send_price(day0_px[i], 1'b0, 1'b1, day0_ex[i], 12'd10);
        for (int i = 0; i < 2; i++) send_est(12'd5, 1'b0);
        @(negedge clk);
        est_valid = 1'b0;
        check("pre_rst_est_ready", 32'(est_ready_a[1]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy_a[1]), 32'd0);
        check("mid_rst_est_ready", 32'(est_ready_a[1]), 32'd0);
        repeat (10) @(negedge clk);
        check("mid_rst_no_price", pv_cnt[1] - pv1, 0);

        // Start and new config while busy are ignored.
        start_run(0, 12'd100, 1'b0, 12'd0);
        for (int i = 0; i < 2; i++) send_price(prices1[i], 1'b0, 1'b0, 12'd0, 12'd0);
        @(negedge clk);
        in_valid   = 1'b0;
        strike     = 12'd0;
        is_put     = 1'b1;
        start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        check("busy_during_run", 32'(busy_a[0]), 32'd1);
        for (int i = 2; i < 4; i++) send_price(prices1[i], 1'b0, 1'b0, 12'd0, 12'd0);
        wait_price("after_rst", 12'd15, 5);
        idle();

        // Full-size run at the top of the range: exercise wins every day.
        start_run(2, 12'd0, 1'b0, 12'd4095);
        for (int i = 0; i < 128; i++) send_price(12'd4095, 1'b0, 1'b0, 12'd0, 12'd0);
        for (int d = 0; d < 7; d++) begin
            for (int i = 0; i < 128; i++) send_price(12'd4095, 1'b0, 1'b1, 12'd4095, 12'd4094);
            for (int i = 0; i < 128; i++) send_est(12'd0, 1'b0);
        end
        wait_price("full_size", 12'd4095, 129);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
